crt_mm_seq: RTL and testbench
=============================

Name: crt_mm_seq

Overview:
Sequencer for the residue quarter-square LUT matrix-multiply datapath in tt_um_dang_crt_mm.
- Walks the output elements of a DIM×DIM × DIM×DIM product.
- For each element, time-multiplexes the shared LUT MAC across NUM_MOD residue channels, issuing one (row, col, k, chan) operand tuple per accepted handshake.
- Triggers CRT reconstruction, then hands the finished element index downstream.
- Sits between the top-level command pins and the MAC/reconstruct datapath.

Parameters:
- DIM, 2, matrix dimension (2..4).
- NUM_MOD, 3, number of residue channels (moduli) sharing the LUT (1..4).
- IDX_W, 2, width of row/col/k index fields; must satisfy 2^IDX_W >= DIM.
- CH_W, 2, width of the channel index; must satisfy 2^CH_W >= NUM_MOD.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a matrix multiply; sampled only in IDLE
- abort  in  1  synchronous cancel of the current multiply
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last element is accepted downstream
- issue_valid  out  1  operand tuple valid to the MAC
- issue_ready  in  1  MAC accepts the tuple
- issue_row  out  IDX_W  output row index i
- issue_col  out  IDX_W  output column index j
- issue_k  out  IDX_W  reduction index k
- issue_chan  out  CH_W  residue channel
- issue_first  out  1  k==0; MAC clears the channel accumulator
- issue_last  out  1  k==DIM-1; MAC commits the channel residue
- recon_start  out  1  one-cycle pulse to the CRT reconstruct stage
- recon_done  in  1  reconstruct result ready (single-cycle pulse)
- out_valid  out  1  reconstructed element available
- out_ready  in  1  downstream accepts the element
- out_row  out  IDX_W  row index of the presented element
- out_col  out  IDX_W  column index of the presented element

Behaviour:
- Reset: state=IDLE; all counters=0; every output=0. The same values are reached one cycle after abort.
- States: IDLE, ISSUE, RECON_REQ, RECON_WAIT, OUTPUT, FINISH.
- IDLE: if start=1, go to ISSUE next cycle with i=j=k=chan=0.
- ISSUE: issue_valid=1. The index outputs are driven from the counters and held stable while issue_ready=0.
  - On issue_valid&issue_ready, advance k; on k wrap, advance chan.
  - The handshake with k==DIM-1 and chan==NUM_MOD-1 goes to RECON_REQ; issue_valid drops the next cycle.
  - Back-to-back acceptance gives one issue per cycle, so DIM*NUM_MOD cycles per element minimum.
- RECON_REQ: recon_start=1 for exactly one cycle, then RECON_WAIT.
- RECON_WAIT: wait for recon_done.
  - recon_done arriving in the same cycle as recon_start is ignored. It is only honoured in RECON_WAIT.
  - On recon_done go to OUTPUT.
- OUTPUT: out_valid=1; out_row=i, out_col=j held until out_ready.
  - On the handshake, advance j; on j wrap, advance i.
  - If i==DIM-1 and j==DIM-1 were just accepted, go to FINISH. Otherwise go to ISSUE with k=chan=0.
- FINISH: done=1 for one cycle; busy=0 from the next cycle; return to IDLE.
- Issue order per element: chan-major, k-minor, e.g. (c0,k0),(c0,k1),(c1,k0),… Elements go row-major.
- Totals per multiply: DIM*DIM*NUM_MOD*DIM issues, DIM*DIM recon_start pulses, DIM*DIM outputs.
- start while busy: ignored, no effect on counters.
- abort: highest priority after rst. In any state it forces IDLE next cycle with no done pulse and no further issues.
  - abort and start in the same IDLE cycle: abort wins, stays IDLE.
- Counters wrap at DIM-1 and NUM_MOD-1, never at 2^width. Unused index encodings are never driven.
- issue_first = (k==0), issue_last = (k==DIM-1), both gated by issue_valid. For DIM=1 both are high together.

Decomposition:
- Package crt_mm_pkg holds:
  - the state enum crt_seq_state_t;
  - default DIM and NUM_MOD;
  - the residue modulus table localparam MODULI[NUM_MOD] (7, 15, 16) shared with the MAC and reconstruct blocks;
  - an issue-tuple struct crt_issue_t {row, col, k, chan, first, last}.
- One sub-module, crt_mm_idx_cnt: a nested wrap counter (inner limit, outer limit, advance, clear) returning the inner value, the outer value, the inner wrap and the final wrap. It is instantiated twice: k/chan and j/i.

Test Plan:
- Nominal run (DIM=2, NUM_MOD=3), issue_ready, out_ready and recon_done (2 cycles after recon_start) always high → exactly 24 issues in order (i0 j0 c0 k0, i0 j0 c0 k1, i0 j0 c1 k0, …), 4 recon_start pulses, outputs (0,0),(0,1),(1,0),(1,1), one done pulse, busy low afterwards.
- Issue backpressure: issue_ready toggles 1,0,0,1 → tuple held stable during stalls, no duplicated or skipped (k, chan), total still 24.
- Output backpressure: out_ready low 5 cycles at element (0,1) → out_valid held with out_row=0, out_col=1, no new issues until accepted.
- Early recon_done asserted in the same cycle as recon_start → ignored; FSM still waits for a later recon_done before out_valid.
- Abort during ISSUE at the 10th issue → next cycle busy=0 and issue_valid=0, no done; a following start restarts from i=j=k=chan=0.
- rst asserted mid-OUTPUT and start pulsed while busy → outputs all 0 after rst; start while busy leaves the sequence unchanged.

Source files
------------

// File: rtl/crt_mm_pkg.sv
// Shared definitions for the residue quarter-square LUT matrix-multiply slice:
// sequencer state encoding, default geometry, modulus table and issue tuple.
package crt_mm_pkg;

    // Default geometry: 2x2 matrices, three residue channels sharing one LUT MAC.
    localparam int unsigned DIM_DEF     = 32'd2;
    localparam int unsigned NUM_MOD_DEF = 32'd3;

    // Residue moduli, channel 0 first. The MAC and reconstruct blocks index
    // this table with issue_chan, so its order must match the channel order.
    localparam int unsigned MODULI [NUM_MOD_DEF] = '{32'd7, 32'd15, 32'd16};

    // Sequencer states. Encodings are fixed so that waveforms and any
    // legacy decoders keep reading the same values.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_RECON_REQ  = 3'd2,
        ST_RECON_WAIT = 3'd3,
        ST_OUTPUT     = 3'd4,
        ST_FINISH     = 3'd5
    } crt_seq_state_t;

    // One operand tuple handed to the MAC. Field widths cover the largest
    // supported geometry (DIM up to 4, up to 4 channels).
    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
        logic [1:0] k;
        logic [1:0] chan;
        logic       first;
        logic       last;
    } crt_issue_t;

endpackage

// File: rtl/crt_mm_idx_cnt.sv
// Nested wrap counter: the inner field counts 0..inner_lim, and each inner wrap
// steps the outer field through 0..outer_lim. Both fields wrap at their limits,
// never at the power of two, so unused encodings are never produced.
// The wrap flags are qualified by advance: they mark the cycle in which the
// wrap actually happens.
module crt_mm_idx_cnt #(
    parameter int unsigned IN_W  = 32'd2,
    parameter int unsigned OUT_W = 32'd2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic [IN_W-1:0]  inner_lim,
    input  logic [OUT_W-1:0] outer_lim,
    output logic [IN_W-1:0]  inner,
    output logic [OUT_W-1:0] outer,
    output logic             inner_wrap,
    output logic             final_wrap
);

    logic [IN_W-1:0]  inner_r;
    logic [IN_W-1:0]  inner_nxt_s;
    logic [OUT_W-1:0] outer_r;
    logic [OUT_W-1:0] outer_nxt_s;

    assign inner_wrap = advance & (inner_r == inner_lim);
    assign final_wrap = inner_wrap & (outer_r == outer_lim);
    assign inner      = inner_r;
    assign outer      = outer_r;

    // Next-count logic: clear beats advance; otherwise hold.
    always_comb begin
        inner_nxt_s = inner_r;
        outer_nxt_s = outer_r;
        if (clear) begin
            inner_nxt_s = '0;
            outer_nxt_s = '0;
        end else if (advance) begin
            if (inner_wrap) begin
                inner_nxt_s = '0;
                if (outer_r == outer_lim) begin
                    outer_nxt_s = '0;
                end else begin
                    outer_nxt_s = outer_r + OUT_W'(1'b1);
                end
            end else begin
                inner_nxt_s = inner_r + IN_W'(1'b1);
                outer_nxt_s = outer_r;
            end
        end else begin
            inner_nxt_s = inner_r;
            outer_nxt_s = outer_r;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            inner_r <= '0;
            outer_r <= '0;
        end else begin
            inner_r <= inner_nxt_s;
            outer_r <= outer_nxt_s;
        end
    end

endmodule

// File: rtl/crt_mm_seq.sv
// Sequencer for the residue LUT matrix multiply. For every output element
// (row-major) it issues DIM reduction steps for each residue channel
// (chan-major, k-minor), requests CRT reconstruction, waits for the result and
// presents the element index downstream. All control outputs are registered
// from the next-state value, so they change exactly with the state.
module crt_mm_seq
    import crt_mm_pkg::*;
#(
    parameter int unsigned DIM     = DIM_DEF,
    parameter int unsigned NUM_MOD = NUM_MOD_DEF,
    parameter int unsigned IDX_W   = 32'd2,
    parameter int unsigned CH_W    = 32'd2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [IDX_W-1:0] issue_row,
    output logic [IDX_W-1:0] issue_col,
    output logic [IDX_W-1:0] issue_k,
    output logic [CH_W-1:0]  issue_chan,
    output logic             issue_first,
    output logic             issue_last,
    output logic             recon_start,
    input  logic             recon_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_row,
    output logic [IDX_W-1:0] out_col
);

    localparam logic [IDX_W-1:0] IDX_LIM = IDX_W'(DIM - 32'd1);
    localparam logic [CH_W-1:0]  CH_LIM  = CH_W'(NUM_MOD - 32'd1);

    crt_seq_state_t   state_r;
    crt_seq_state_t   state_nxt_s;

    logic             issue_hs_s;
    logic             out_hs_s;
    logic             clr_s;

    logic [IDX_W-1:0] k_s;
    logic [CH_W-1:0]  chan_s;
    logic [IDX_W-1:0] i_s;
    logic [IDX_W-1:0] j_s;
    logic             k_wrap_s;
    logic             kc_final_s;
    logic             j_wrap_s;
    logic             ij_final_s;

    logic             k_zero_nxt_s;
    logic             k_last_nxt_s;

    logic             busy_r;
    logic             done_r;
    logic             issue_valid_r;
    logic             issue_first_r;
    logic             issue_last_r;
    logic             recon_start_r;
    logic             out_valid_r;

    // Handshakes are void in an abort cycle so the counters never step then.
    assign issue_hs_s = (state_r == ST_ISSUE) & issue_ready & ~abort;
    assign out_hs_s   = (state_r == ST_OUTPUT) & out_ready & ~abort;
    assign clr_s      = abort | ((state_r == ST_IDLE) & start);

    // k (inner) / channel (outer): one step per accepted operand tuple.
    crt_mm_idx_cnt #(
        .IN_W  (IDX_W),
        .OUT_W (CH_W)
    ) u_kc_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear      (clr_s),
        .advance    (issue_hs_s),
        .inner_lim  (IDX_LIM),
        .outer_lim  (CH_LIM),
        .inner      (k_s),
        .outer      (chan_s),
        .inner_wrap (k_wrap_s),
        .final_wrap (kc_final_s)
    );

    // Column j (inner) / row i (outer): one step per accepted output element.
    crt_mm_idx_cnt #(
        .IN_W  (IDX_W),
        .OUT_W (IDX_W)
    ) u_ij_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear      (clr_s),
        .advance    (out_hs_s),
        .inner_lim  (IDX_LIM),
        .outer_lim  (IDX_LIM),
        .inner      (j_s),
        .outer      (i_s),
        .inner_wrap (j_wrap_s),
        .final_wrap (ij_final_s)
    );

    // Look-ahead of k so issue_first/issue_last can be registered with the tuple.
    always_comb begin
        k_zero_nxt_s = 1'b0;
        k_last_nxt_s = 1'b0;
        if (clr_s) begin
            k_zero_nxt_s = 1'b1;
            k_last_nxt_s = (IDX_LIM == '0);
        end else if (issue_hs_s) begin
            k_zero_nxt_s = k_wrap_s;
            k_last_nxt_s = ~k_wrap_s & ((k_s + IDX_W'(1'b1)) == IDX_LIM);
        end else begin
            k_zero_nxt_s = (k_s == '0);
            k_last_nxt_s = (k_s == IDX_LIM);
        end
    end

    // Next-state logic; abort overrides everything except rst.
    always_comb begin
        state_nxt_s = state_r;
        if (abort) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt_s = ST_ISSUE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (kc_final_s) begin
                        state_nxt_s = ST_RECON_REQ;
                    end else begin
                        state_nxt_s = ST_ISSUE;
                    end
                end
                ST_RECON_REQ: begin
                    // recon_done seen here belongs to no request of ours.
                    state_nxt_s = ST_RECON_WAIT;
                end
                ST_RECON_WAIT: begin
                    if (recon_done) begin
                        state_nxt_s = ST_OUTPUT;
                    end else begin
                        state_nxt_s = ST_RECON_WAIT;
                    end
                end
                ST_OUTPUT: begin
                    if (out_hs_s) begin
                        // Column wrap with the row at its limit: last element gone.
                        if (j_wrap_s && ij_final_s) begin
                            state_nxt_s = ST_FINISH;
                        end else begin
                            state_nxt_s = ST_ISSUE;
                        end
                    end else begin
                        state_nxt_s = ST_OUTPUT;
                    end
                end
                ST_FINISH: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered control outputs, all decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            issue_valid_r <= 1'b0;
            issue_first_r <= 1'b0;
            issue_last_r  <= 1'b0;
            recon_start_r <= 1'b0;
            out_valid_r   <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            busy_r        <= (state_nxt_s != ST_IDLE);
            done_r        <= (state_nxt_s == ST_FINISH);
            issue_valid_r <= (state_nxt_s == ST_ISSUE);
            issue_first_r <= (state_nxt_s == ST_ISSUE) & k_zero_nxt_s;
            issue_last_r  <= (state_nxt_s == ST_ISSUE) & k_last_nxt_s;
            recon_start_r <= (state_nxt_s == ST_RECON_REQ);
            out_valid_r   <= (state_nxt_s == ST_OUTPUT);
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign issue_valid = issue_valid_r;
    assign issue_first = issue_first_r;
    assign issue_last  = issue_last_r;
    assign recon_start = recon_start_r;
    assign out_valid   = out_valid_r;
    assign issue_row   = i_s;
    assign issue_col   = j_s;
    assign issue_k     = k_s;
    assign issue_chan  = chan_s;
    assign out_row     = i_s;
    assign out_col     = j_s;

endmodule

// File: tb/tb_crt_mm_seq.sv
// Directed bench for crt_mm_seq (DIM=2, NUM_MOD=3): a cycle table for the
// first element plus full-multiply sequences checked against a tuple list.
module tb_crt_mm_seq;
    import crt_mm_pkg::*;

    localparam int T_DIM   = 2;
    localparam int T_NMOD  = 3;
    localparam int T_NISS  = T_DIM * T_DIM * T_NMOD * T_DIM;
    localparam int T_NOUT  = T_DIM * T_DIM;
    localparam int T_NVEC  = 17;

    logic       clk = 1'b0;
    logic       rst, start, abort, issue_ready, recon_done, out_ready;
    logic       busy, done, issue_valid, issue_first, issue_last;
    logic       recon_start, out_valid;
    logic [1:0] issue_row, issue_col, issue_k, issue_chan, out_row, out_col;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        start;
        logic        abort;
        logic        ir;
        logic        rd;
        logic        ordy;
        logic [18:0] exp;
    } vec_t;

    vec_t       tbl   [T_NVEC];
    crt_issue_t exp_a [T_NISS];

    crt_mm_seq #(
        .DIM     (32'd2),
        .NUM_MOD (32'd3),
        .IDX_W   (32'd2),
        .CH_W    (32'd2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_row   (issue_row),
        .issue_col   (issue_col),
        .issue_k     (issue_k),
        .issue_chan  (issue_chan),
        .issue_first (issue_first),
        .issue_last  (issue_last),
        .recon_start (recon_start),
        .recon_done  (recon_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_col     (out_col)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [18:0] obs();
        return {busy, issue_valid, issue_row, issue_col, issue_k, issue_chan,
                issue_first, issue_last, recon_start, out_valid, out_row, out_col, done};
    endfunction

    function automatic logic [18:0] mk(input logic b, input logic iv,
                                       input logic [1:0] i, input logic [1:0] j,
                                       input logic [1:0] k, input logic [1:0] c,
                                       input logic f, input logic l, input logic rs,
                                       input logic ov, input logic dn);
        return {b, iv, i, j, k, c, f, l, rs, ov, i, j, dn};
    endfunction

    function automatic vec_t vec(input logic s, input logic a, input logic ir,
                                 input logic rd, input logic ordy, input logic [18:0] e);
        vec_t v;
        v.start = s;
        v.abort = a;
        v.ir    = ir;
        v.rd    = rd;
        v.ordy  = ordy;
        v.exp   = e;
        return v;
    endfunction

    function automatic crt_issue_t cur_issue();
        crt_issue_t t;
        t.row   = issue_row;
        t.col   = issue_col;
        t.k     = issue_k;
        t.chan  = issue_chan;
        t.first = issue_first;
        t.last  = issue_last;
        return t;
    endfunction

    // One complete multiply. mode 0: all ready; mode 1: issue_ready 1,0,0,1
    // pattern plus a start pulse while busy; mode 2: out_ready low 5 cycles at (0,1).
    task automatic run_full(input int mode);
        int         issues = 0;
        int         recons = 0;
        int         outs   = 0;
        int         pidx   = 0;
        int         rd_cnt = 0;
        int         stall  = 5;
        int         cyc    = 0;
        bit         seen_done = 1'b0;
        bit         held_v    = 1'b0;
        crt_issue_t cur;
        crt_issue_t held;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!seen_done && cyc < 400) begin
            if (mode == 1) issue_ready = ((pidx % 4) == 0) || ((pidx % 4) == 3);
            else           issue_ready = 1'b1;
            start = (mode == 1) && (cyc == 5);
            if (issue_valid) begin
                cur = cur_issue();
                if (held_v) check($sformatf("m%0d_issue_hold", mode), 32'(cur), 32'(held));
                if (issue_ready) begin
                    check($sformatf("m%0d_issue_count_ok", mode), 32'(issues < T_NISS), 32'd1);
                    if (issues < T_NISS)
                        check($sformatf("m%0d_issue[%0d]", mode, issues), 32'(cur), 32'(exp_a[issues]));
                    issues++;
                    held_v = 1'b0;
                end else begin
                    held   = cur;
                    held_v = 1'b1;
                end
                pidx++;
            end
            recon_done = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                recon_done = (rd_cnt == 0);
            end
            if (recon_start) begin
                recons++;
                rd_cnt = 2;
            end
            out_ready = 1'b0;
            if (out_valid) begin
                if (mode == 2 && outs == 1 && stall > 0) begin
                    stall--;
                    check("m2_stall_no_issue", 32'(issue_valid), 32'd0);
                    check("m2_stall_pos", 32'({out_row, out_col}), 32'({2'd0, 2'd1}));
                end else begin
                    out_ready = 1'b1;
                    check($sformatf("m%0d_out[%0d]", mode, outs), 32'({out_row, out_col}),
                          32'({2'(outs / T_DIM), 2'(outs % T_DIM)}));
                    outs++;
                end
            end
            if (done) seen_done = 1'b1;
            tick();
            cyc++;
        end
        issue_ready = 1'b0;
        out_ready   = 1'b0;
        recon_done  = 1'b0;
        start       = 1'b0;
        check($sformatf("m%0d_done_seen", mode), 32'(seen_done), 32'd1);
        check($sformatf("m%0d_issue_total", mode), 32'(issues), 32'(T_NISS));
        check($sformatf("m%0d_recon_total", mode), 32'(recons), 32'(T_NOUT));
        check($sformatf("m%0d_out_total", mode), 32'(outs), 32'(T_NOUT));
        check($sformatf("m%0d_busy_after", mode), 32'(busy), 32'd0);
        check($sformatf("m%0d_done_single", mode), 32'(done), 32'd0);
    endtask

    initial begin
        int n = 0;
        int cnt = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        issue_ready = 1'b0; recon_done = 1'b0; out_ready = 1'b0;

        // Expected issue order: elements row-major, then chan-major, k-minor.
        for (int i = 0; i < T_DIM; i++)
            for (int j = 0; j < T_DIM; j++)
                for (int c = 0; c < T_NMOD; c++)
                    for (int k = 0; k < T_DIM; k++) begin
                        exp_a[n].row   = 2'(i);
                        exp_a[n].col   = 2'(j);
                        exp_a[n].k     = 2'(k);
                        exp_a[n].chan  = 2'(c);
                        exp_a[n].first = (k == 0);
                        exp_a[n].last  = (k == T_DIM - 1);
                        n++;
                    end

        // First element cycle by cycle: inputs (start, abort, issue_ready,
        // recon_done, out_ready), then the outputs after the clock edge.
        tbl[0]  = vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[1]  = vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(1'b1, 1'b1, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[2]  = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b1, 1'b1, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[3]  = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b1, 1'b1, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[4]  = vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[5]  = vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(1'b1, 1'b1, 2'd0, 2'd0, 2'd1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[6]  = vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[7]  = vec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mk(1'b1, 1'b1, 2'd0, 2'd0, 2'd1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[8]  = vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        tbl[9]  = vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[10] = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[11] = vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        tbl[12] = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        tbl[13] = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(1'b1, 1'b1, 2'd0, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[14] = vec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 19'd0);
        tbl[15] = vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 19'd0);
        tbl[16] = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 19'd0);

        tick();
        tick();
        check("reset_state", 32'(obs()), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_after_reset", 32'(obs()), 32'd0);

        for (int v = 0; v < T_NVEC; v++) begin
            start       = tbl[v].start;
            abort       = tbl[v].abort;
            issue_ready = tbl[v].ir;
            recon_done  = tbl[v].rd;
            out_ready   = tbl[v].ordy;
            tick();
            check($sformatf("vec[%0d]", v), 32'(obs()), 32'(tbl[v].exp));
        end
        start = 1'b0; abort = 1'b0; issue_ready = 1'b0; recon_done = 1'b0; out_ready = 1'b0;

        run_full(0);
        run_full(1);
        run_full(2);

        // Abort while the 10th tuple is on the bus.
        issue_ready = 1'b1; recon_done = 1'b1; out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 100 && cnt < 9; c++) begin
            if (issue_valid) cnt++;
            tick();
        end
        check("abort_pre_valid", 32'(issue_valid), 32'd1);
        check("abort_pre_tuple", 32'(cur_issue()), 32'(exp_a[9]));
        abort = 1'b1;
        tick();
        abort = 1'b0; issue_ready = 1'b0; recon_done = 1'b0; out_ready = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_issue_valid", 32'(issue_valid), 32'd0);
        check("abort_all_zero", 32'(obs()), 32'd0);
        tick();
        check("abort_stays_idle", 32'(obs()), 32'd0);

        run_full(0);

        // rst in the middle of OUTPUT, with a start pulse while busy first.
        issue_ready = 1'b1; recon_done = 1'b1; out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 50 && !out_valid; c++) tick();
        check("rst_reach_output", 32'(out_valid), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_out_valid", 32'(out_valid), 32'd1);
        check("busy_start_pos", 32'({out_row, out_col}), 32'd0);
        check("busy_start_no_issue", 32'(issue_valid), 32'd0);
        rst = 1'b1;
        tick();
        check("rst_mid_output", 32'(obs()), 32'd0);
        rst = 1'b0; issue_ready = 1'b0; recon_done = 1'b0;
        tick();
        check("post_rst_idle", 32'(obs()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
